// File: rtl/mem_if_pkg.sv
// Shared definitions for the memory interface block.
//   - mem_cmd encodings (MNONE / MREAD / MWRITE; 2'b10 is illegal and treated as none)
//   - memory-mapped I/O addresses (LED_ADDR, SW_ADDR)
//   - FSM state encoding
package mem_if_pkg;

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b11;

    localparam logic [8:0] LED_ADDR = 9'h100;
    localparam logic [8:0] SW_ADDR  = 9'h140;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/mem_if_pc_reg.sv
// Program counter, data-address register and memory address mux.
// Ports:
//   clk, reset (async, active-low)
//   load_pc, reset_pc : pc <= 0 when both set, pc <= pc+1 when load_pc alone
//   load_addr, data_in: data_addr <= data_in when load_addr set
//   addr_sel          : 1 -> mem_addr = pc, 0 -> mem_addr = data_addr
//   pc, data_addr, mem_addr : register values and muxed address
module pc_reg
    import mem_if_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load_pc,
    input  logic       reset_pc,
    input  logic       load_addr,
    input  logic       addr_sel,
    input  logic [8:0] data_in,
    output logic [8:0] pc,
    output logic [8:0] data_addr,
    output logic [8:0] mem_addr
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc        <= 9'd0;
            data_addr <= 9'd0;
        end else begin
            // reset_pc only acts together with load_pc; pc wraps 0x1FF -> 0x000
            if (load_pc)
                pc <= reset_pc ? 9'd0 : pc + 9'd1;
            if (load_addr)
                data_addr <= data_in;
        end
    end

    assign mem_addr = addr_sel ? pc : data_addr;

endmodule

// File: rtl/mem_if.sv
// Memory interface: sequences RAM reads (with programmable latency), RAM
// writes, and memory-mapped LED (write) / switch (read) accesses.
// Ports:
//   clk, reset (async, active-low)
//   mem_cmd[1:0]      : 00 none, 01 read, 11 write, 10 treated as none
//   addr_sel          : address source select (1 pc, 0 data_addr)
//   load_pc, reset_pc, load_addr : register controls
//   datapath_out[15:0]: write data and data-address source
//   switches[7:0]     : board switches (read at 0x140)
//   ram_dout[15:0]    : RAM read data
//   ram_addr[7:0], ram_din[15:0], ram_we : RAM port
//   pc[8:0]           : program counter
//   read_data[15:0]   : latched read result
//   mem_ready         : one-cycle completion pulse
//   leds[7:0]         : LED register (written at 0x100)
//
// state   | meaning
// IDLE    | accepting commands; writes execute here
// RD_WAIT | read in flight, counting down RAM latency
// DONE    | mem_ready pulse, back to IDLE next cycle
module mem_if
    import mem_if_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mem_cmd,
    input  logic        addr_sel,
    input  logic        load_pc,
    input  logic        reset_pc,
    input  logic        load_addr,
    input  logic [15:0] datapath_out,
    input  logic [7:0]  switches,
    input  logic [15:0] ram_dout,
    output logic [7:0]  ram_addr,
    output logic [15:0] ram_din,
    output logic        ram_we,
    output logic [8:0]  pc,
    output logic [15:0] read_data,
    output logic        mem_ready,
    output logic [7:0]  leds
);

    localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

    state_t      state, state_next;
    logic [8:0]  data_addr;
    logic [8:0]  mem_addr;
    logic [8:0]  req_addr;
    logic [2:0]  cnt;
    logic [1:0]  prev_cmd;
    logic        write_pending;

    logic        wr_edge;
    logic        do_write;
    logic        start_read;
    logic        finish_read;
    logic        led_we;
    logic [15:0] rd_value;

    pc_reg u_pc_reg (
        .clk       (clk),
        .reset     (reset),
        .load_pc   (load_pc),
        .reset_pc  (reset_pc),
        .load_addr (load_addr),
        .addr_sel  (addr_sel),
        .data_in   (datapath_out[8:0]),
        .pc        (pc),
        .data_addr (data_addr),
        .mem_addr  (mem_addr)
    );

    // One write per transition into MWRITE, regardless of how long it is held
    assign wr_edge = (mem_cmd == MWRITE) && (prev_cmd != MWRITE);

    always_comb begin
        if (req_addr[8] == 1'b0)
            rd_value = ram_dout;
        else if (req_addr == SW_ADDR)
            rd_value = {8'h00, switches};
        else
            rd_value = 16'h0000;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next  = state;
        do_write    = 1'b0;
        start_read  = 1'b0;
        finish_read = 1'b0;
        ram_we      = 1'b0;
        led_we      = 1'b0;
        mem_ready   = 1'b0;
        ram_addr    = mem_addr[7:0];
        ram_din     = datapath_out;
        case (state)
            S_IDLE: begin
                // A pending write wins over a read held on mem_cmd
                if (wr_edge || write_pending) begin
                    do_write   = 1'b1;
                    // gated by reset so the strobe is low while reset is held
                    ram_we     = reset && !mem_addr[8];
                    led_we     = (mem_addr == LED_ADDR);
                    state_next = S_DONE;
                end else if (mem_cmd == MREAD) begin
                    start_read = 1'b1;
                    state_next = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                ram_addr = req_addr[7:0];
                if (cnt == 3'd0) begin
                    finish_read = 1'b1;
                    state_next  = S_DONE;
                end
            end
            S_DONE: begin
                mem_ready  = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_cmd      <= MNONE;
            write_pending <= 1'b0;
            req_addr      <= 9'd0;
            cnt           <= 3'd0;
            read_data     <= 16'h0000;
            leds          <= 8'h00;
        end else begin
            prev_cmd <= mem_cmd;

            if (do_write)
                write_pending <= 1'b0;
            else if (wr_edge && state != S_IDLE)
                write_pending <= 1'b1;

            if (start_read) begin
                req_addr <= mem_addr;
                cnt      <= WAIT_INIT;
            end else if (state == S_RD_WAIT && cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end

            if (finish_read)
                read_data <= rd_value;

            if (led_we)
                leds <= datapath_out[7:0];
        end
    end

endmodule

// File: tb/tb_mem_if.sv
module tb_mem_if;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mem_cmd;
    logic        addr_sel;
    logic        load_pc;
    logic        reset_pc;
    logic        load_addr;
    logic [15:0] datapath_out;
    logic [7:0]  switches;
    logic [15:0] ram_dout;
    logic [7:0]  ram_addr;
    logic [15:0] ram_din;
    logic        ram_we;
    logic [8:0]  pc;
    logic [15:0] read_data;
    logic        mem_ready;
    logic [7:0]  leds;

    int checks = 0;
    int errors = 0;

    logic [15:0] ram [0:255];

    always #5 clk = ~clk;

    mem_if #(.WAIT_CYCLES(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_cmd      (mem_cmd),
        .addr_sel     (addr_sel),
        .load_pc      (load_pc),
        .reset_pc     (reset_pc),
        .load_addr    (load_addr),
        .datapath_out (datapath_out),
        .switches     (switches),
        .ram_dout     (ram_dout),
        .ram_addr     (ram_addr),
        .ram_din      (ram_din),
        .ram_we       (ram_we),
        .pc           (pc),
        .read_data    (read_data),
        .mem_ready    (mem_ready),
        .leds         (leds)
    );

    assign ram_dout = ram[ram_addr];
    always @(posedge clk) if (ram_we) ram[ram_addr] <= ram_din;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input logic [15:0] v);
        datapath_out = v;
        load_addr = 1'b1;
        tick();
        load_addr = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [15:0] exp);
        int n;
        mem_cmd = 2'b01;
        tick();
        mem_cmd = 2'b00;
        n = 0;
        while (mem_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, 32'(mem_ready), 32'h1);
        check(tag, 32'(read_data), 32'(exp));
        tick();
    endtask

    initial begin
        int we_count;
        int done_count;
        logic [7:0]  we_addr;
        logic [15:0] we_din;

        for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
        ram[0] = 16'h1111;
        ram[5] = 16'hABCD;

        reset = 1'b0;
        mem_cmd = 2'b00;
        addr_sel = 1'b0;
        load_pc = 1'b0;
        reset_pc = 1'b0;
        load_addr = 1'b0;
        datapath_out = 16'h0000;
        switches = 8'h00;
        #2;
        check("rst_pc", 32'(pc), 32'h0);
        check("rst_read_data", 32'(read_data), 32'h0);
        check("rst_leds", 32'(leds), 32'h0);
        check("rst_mem_ready", 32'(mem_ready), 32'h0);
        check("rst_ram_we", 32'(ram_we), 32'h0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // PC reset and increment
        load_pc = 1'b1; reset_pc = 1'b1;
        tick();
        check("pc_reset", 32'(pc), 32'h0);
        reset_pc = 1'b0;
        tick(); tick(); tick();
        check("pc_inc3", 32'(pc), 32'h3);
        // reset_pc alone has no effect
        load_pc = 1'b0; reset_pc = 1'b1;
        tick();
        reset_pc = 1'b0;
        check("pc_reset_only", 32'(pc), 32'h3);

        // PC wrap
        load_pc = 1'b1;
        for (int i = 0; i < 508; i++) tick();
        check("pc_1ff", 32'(pc), 32'h1FF);
        tick();
        check("pc_wrap", 32'(pc), 32'h0);
        for (int i = 0; i < 5; i++) tick();
        load_pc = 1'b0;
        check("pc_5", 32'(pc), 32'h5);

        // RAM read via pc, latency, and address stability during RD_WAIT
        addr_sel = 1'b1;
        mem_cmd = 2'b01;
        tick();
        check("rd_ram_addr", 32'(ram_addr), 32'h05);
        check("rd_ready_t0", 32'(mem_ready), 32'h0);
        addr_sel = 1'b0;
        mem_cmd = 2'b00;
        #1;
        check("rd_addr_hold", 32'(ram_addr), 32'h05);
        tick();
        check("rd_ready_t1", 32'(mem_ready), 32'h0);
        tick();
        check("rd_ready_t2", 32'(mem_ready), 32'h1);
        check("rd_data", 32'(read_data), 32'hABCD);
        tick();
        check("rd_ready_t3", 32'(mem_ready), 32'h0);
        check("rd_data_hold", 32'(read_data), 32'hABCD);

        // LED write, held 5 cycles
        set_addr(16'h0100);
        datapath_out = 16'h00A5;
        mem_cmd = 2'b11;
        we_count = 0;
        done_count = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (ram_we === 1'b1) we_count++;
            tick();
            if (mem_ready === 1'b1) done_count++;
        end
        mem_cmd = 2'b00;
        tick();
        check("led_value", 32'(leds), 32'hA5);
        check("led_done_count", 32'(done_count), 32'd1);
        check("led_no_ram_we", 32'(we_count), 32'd0);

        // RAM write and read-back
        set_addr(16'h0010);
        datapath_out = 16'h1234;
        mem_cmd = 2'b11;
        #1;
        check("wr_we", 32'(ram_we), 32'h1);
        check("wr_addr", 32'(ram_addr), 32'h10);
        check("wr_din", 32'(ram_din), 32'h1234);
        tick();
        check("wr_we_off", 32'(ram_we), 32'h0);
        check("wr_ready", 32'(mem_ready), 32'h1);
        mem_cmd = 2'b00;
        tick();
        do_read("wr_readback", 16'h1234);

        // switches and unmapped reads
        switches = 8'h3C;
        set_addr(16'h0140);
        do_read("sw_read", 16'h003C);
        set_addr(16'h0180);
        do_read("unmapped_read", 16'h0000);

        // write arriving during RD_WAIT becomes pending and beats a held read
        set_addr(16'h0020);
        datapath_out = 16'h5678;
        mem_cmd = 2'b01;
        tick();
        mem_cmd = 2'b11;
        tick();
        mem_cmd = 2'b01;
        we_count = 0;
        we_addr = 8'h00;
        we_din = 16'h0000;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (ram_we === 1'b1) begin
                we_count++;
                we_addr = ram_addr;
                we_din = ram_din;
            end
            tick();
        end
        mem_cmd = 2'b00;
        check("pend_we_count", 32'(we_count), 32'd1);
        check("pend_addr", 32'(we_addr), 32'h20);
        check("pend_din", 32'(we_din), 32'h5678);
        for (int i = 0; i < 6; i++) tick();
        do_read("pend_readback", 16'h5678);

        // reset in the middle of a read
        set_addr(16'h0005);
        mem_cmd = 2'b01;
        tick();
        mem_cmd = 2'b00;
        tick();
        reset = 1'b0;
        #1;
        check("mid_rst_pc", 32'(pc), 32'h0);
        check("mid_rst_read_data", 32'(read_data), 32'h0);
        check("mid_rst_leds", 32'(leds), 32'h0);
        check("mid_rst_ready", 32'(mem_ready), 32'h0);
        check("mid_rst_we", 32'(ram_we), 32'h0);
        tick();
        reset = 1'b1;
        done_count = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (mem_ready === 1'b1) done_count++;
        end
        check("post_rst_no_ready", 32'(done_count), 32'd0);
        check("post_rst_read_data", 32'(read_data), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
